// File: rtl/lcd_fmt_pkg.sv
// Shared definitions for the LCD message formatter: mode codes, FSM states, ASCII and message constants.
package lcd_fmt_pkg;

    localparam int unsigned CHARS  = 16;
    localparam int unsigned TIME_W = 10;
    localparam int unsigned BCD_W  = 12;
    localparam int unsigned LINE_W = 8 * CHARS;

    typedef enum logic [1:0] {
        MODE_READY = 2'd0,
        MODE_WAIT  = 2'd1,
        MODE_TIME  = 2'd2,
        MODE_EARLY = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONVERT = 3'd1,
        ST_FORMAT  = 3'd2,
        ST_STROBE  = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    // Leftmost character occupies the most significant byte.
    localparam logic [LINE_W-1:0] MSG_BLANK = "                ";
    localparam logic [LINE_W-1:0] MSG_READY = "PRESS TO START  ";
    localparam logic [LINE_W-1:0] MSG_WAIT  = "WAIT...         ";
    localparam logic [LINE_W-1:0] MSG_TIME  = "TIME: 000 ms    ";
    localparam logic [LINE_W-1:0] MSG_EARLY = "TOO SOON!       ";

endpackage

// File: rtl/lcd_bcd_serial.sv
// Iterative double-dabble converter: 10-bit binary to three BCD digits, one bit per cycle.
module lcd_bcd_serial
    import lcd_fmt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TIME_W-1:0] value,
    output logic              done_c,
    output logic [BCD_W-1:0]  bcd
);

    logic [TIME_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              run_q, run_d;
    logic [BCD_W-1:0]  adj_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    // Add 3 to any digit >= 5 before shifting so it carries correctly into the next digit.
    always_comb begin
        adj_c = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_c = 1'b0;
        if (start) begin
            bin_d = value;
            bcd_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            {bcd_d, bin_d} = {adj_c[BCD_W-2:0], bin_q, 1'b0};
            cnt_d          = cnt_q + 4'd1;
            if (cnt_q == 4'd9) begin
                done_c = 1'b1;
                run_d  = 1'b0;
            end
        end
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/lcd_msg_formatter.sv
// Builds the 16-character LCD line and Go strobe from a reaction time and status mode.
// Optional macro LCD_ZERO_BLANK_EN blanks leading zero digits of the displayed time.
module lcd_msg_formatter
    import lcd_fmt_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 2000000,
    parameter int unsigned MAX_MS         = 999
)(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Update,
    input  logic [1:0]        Mode,
    input  logic [TIME_W-1:0] Time,
    output logic              Busy,
    output logic              Go,
    output logic [8*CHARS:1]  Display
);

    localparam int unsigned CNT_W = $clog2(REFRESH_CYCLES + 1);

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [LINE_W-1:0]  disp_q, disp_d;
    logic               go_q, go_d;
    logic               busy_q, busy_d;
    logic               bcd_start_c;
    logic               bcd_done_c;
    logic [TIME_W-1:0]  time_sat_c;
    logic [BCD_W-1:0]   bcd;

    assign time_sat_c = (Time > TIME_W'(MAX_MS)) ? TIME_W'(MAX_MS) : Time;

    lcd_bcd_serial u_bcd (
        .clk    (Clk),
        .rst    (Rst),
        .start  (bcd_start_c),
        .value  (time_sat_c),
        .done_c (bcd_done_c),
        .bcd    (bcd)
    );

    function automatic logic [LINE_W-1:0] build_line(input mode_t m, input logic [BCD_W-1:0] d);
        logic [LINE_W-1:0] line;
        logic [7:0]        c2, c1, c0;
        c2 = ASCII_ZERO + {4'h0, d[11:8]};
        c1 = ASCII_ZERO + {4'h0, d[7:4]};
        c0 = ASCII_ZERO + {4'h0, d[3:0]};
`ifdef LCD_ZERO_BLANK_EN
        if (d[11:8] == 4'd0) begin
            c2 = ASCII_SPACE;
            if (d[7:4] == 4'd0) begin
                c1 = ASCII_SPACE;
            end
        end
`endif
        case (m)
            MODE_READY: line = MSG_READY;
            MODE_WAIT:  line = MSG_WAIT;
            MODE_EARLY: line = MSG_EARLY;
            default: begin
                line        = MSG_TIME;
                line[79:72] = c2;
                line[71:64] = c1;
                line[63:56] = c0;
            end
        endcase
        return line;
    endfunction

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_READY;
            hold_q  <= '0;
            disp_q  <= MSG_BLANK;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            hold_q  <= hold_d;
            disp_q  <= disp_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        hold_d      = hold_q;
        disp_d      = disp_q;
        bcd_start_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Update) begin
                    mode_d      = mode_t'(Mode);
                    bcd_start_c = 1'b1;
                    state_d     = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (bcd_done_c) begin
                    state_d = ST_FORMAT;
                end
            end
            ST_FORMAT: begin
                disp_d  = build_line(mode_q, bcd);
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                hold_d  = '0;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_q == CNT_W'(REFRESH_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs are registered from the next state so they align with the state they describe.
        go_d   = (state_d == ST_STROBE);
        busy_d = (state_d != ST_IDLE);
    end

    assign Busy    = busy_q;
    assign Go      = go_q;
    assign Display = disp_q;

endmodule

// File: tb/tb_lcd_msg_formatter.sv
// Directed self-checking bench for lcd_msg_formatter with a short refresh hold-off.
module tb_lcd_msg_formatter;

    localparam int unsigned R = 8;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         Update;
    logic [1:0]   Mode;
    logic [9:0]   Time;
    logic         Busy;
    logic         Go;
    logic [128:1] Display;

    int checks   = 0;
    int failures = 0;

    lcd_msg_formatter #(.REFRESH_CYCLES(R), .MAX_MS(999)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Update  (Update),
        .Mode    (Mode),
        .Time    (Time),
        .Busy    (Busy),
        .Go      (Go),
        .Display (Display)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_line(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full request: Update at cycle 0, inputs scrambled after acceptance, Go/Busy timing tracked.
    task automatic run_msg(input string tag, input logic [1:0] m, input logic [9:0] t,
                           input logic [127:0] exp);
        int go_cnt;
        int go_at;
        int busy_bad;
        go_cnt   = 0;
        go_at    = -1;
        busy_bad = 0;
        Mode   = m;
        Time   = t;
        Update = 1'b1;
        for (int cyc = 1; cyc <= 15 + int'(R); cyc++) begin
            tick();
            if (cyc == 1) begin
                Update = 1'b0;
                Mode   = ~m;
                Time   = ~t;
            end
            if (Go === 1'b1) begin
                go_cnt++;
                go_at = cyc;
            end
            if (Busy !== (cyc <= 12 + int'(R))) busy_bad++;
        end
        check_int({tag, "_go_cycle"}, go_at, 12);
        check_int({tag, "_go_count"}, go_cnt, 1);
        check_int({tag, "_busy_bad_cycles"}, busy_bad, 0);
        check_line({tag, "_display"}, Display, exp);
    endtask

    initial begin
        logic [127:0] exp5;
        logic [127:0] exp0;
        int           go_cnt;

        Rst    = 1'b1;
        Update = 1'b0;
        Mode   = 2'd0;
        Time   = 10'd0;
        repeat (3) tick();
        Rst = 1'b0;
        check_line("reset_display", Display, "                ");
        check_int("reset_go", int'(Go), 0);
        check_int("reset_busy", int'(Busy), 0);

        run_msg("t247", 2'd2, 10'd247, "TIME: 247 ms    ");
        run_msg("t1023", 2'd2, 10'd1023, "TIME: 999 ms    ");
        run_msg("t1000", 2'd2, 10'd1000, "TIME: 999 ms    ");
        run_msg("t100", 2'd2, 10'd100, "TIME: 100 ms    ");
`ifdef LCD_ZERO_BLANK_EN
        exp5 = "TIME:   5 ms    ";
        exp0 = "TIME:   0 ms    ";
`else
        exp5 = "TIME: 005 ms    ";
        exp0 = "TIME: 000 ms    ";
`endif
        run_msg("t5", 2'd2, 10'd5, exp5);
        run_msg("t0", 2'd2, 10'd0, exp0);
        run_msg("wait", 2'd1, 10'd33, "WAIT...         ");

        // Second Update while busy is dropped, not queued.
        go_cnt = 0;
        Mode   = 2'd3;
        Time   = 10'd12;
        Update = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick();
            Update = 1'b0;
            if (cyc == 5) begin
                Mode   = 2'd0;
                Update = 1'b1;
            end
            if (Go === 1'b1) go_cnt++;
        end
        check_int("ignore_go_count", go_cnt, 1);
        check_line("ignore_display", Display, "TOO SOON!       ");
        check_int("ignore_busy", int'(Busy), 0);

        run_msg("ready", 2'd0, 10'd0, "PRESS TO START  ");

        // Reset during conversion aborts the request without a Go.
        go_cnt = 0;
        Mode   = 2'd2;
        Time   = 10'd321;
        Update = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick();
            Update = 1'b0;
            Rst    = (cyc == 6);
            if (Go === 1'b1) go_cnt++;
        end
        Rst = 1'b0;
        check_int("abort_go_count", go_cnt, 0);
        check_line("abort_display", Display, "                ");
        check_int("abort_busy", int'(Busy), 0);

        run_msg("after_abort", 2'd2, 10'd58, "TIME: 058 ms    ");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_msg_formatter.md
Name: lcd_msg_formatter

Overview:
- Sits directly upstream of the LCD interface and produces its 128-bit Display line and its Go strobe.
- Accepts a reaction-time result (binary ms) and a status mode from the reaction-timer control FSM.
- Converts the time to BCD serially, formats a fixed 16-character ASCII line, pulses Go, then holds off further updates for a refresh interval so the LCD can finish writing.

Parameters:
- REFRESH_CYCLES, 2000000, Busy hold-off after Go in clock cycles (40 ms at 50 MHz); minimum 1; counter width $clog2(REFRESH_CYCLES+1).
- MAX_MS, 999, saturation value for the displayed time.

Ports:
- Clk  input  1  system clock
- Rst  input  1  synchronous, active-high reset
- Update  input  1  request a new message; sampled only when Busy=0
- Mode  input  2  0=READY, 1=WAIT, 2=TIME, 3=EARLY
- Time  input  10  reaction time in ms, unsigned binary
- Busy  output  1  high while a request is in progress or in hold-off
- Go  output  1  one-cycle strobe to the LCD interface
- Display  output  128  [8*16:1] ASCII line; char 0 (leftmost) at Display[128:121], char 15 at Display[8:1]

Behaviour:
- Reset values: Go=0, Busy=0, Display=16 x 8'h20 (spaces), FSM=IDLE. Reset applies from any state, including mid-conversion; no Go is issued for an aborted request.
- States: IDLE -> CONVERT -> FORMAT -> STROBE -> HOLD -> IDLE.
- IDLE: if Update=1, latch Mode and Time and go to CONVERT; Busy goes high the next cycle.
- Time latch saturates: if Time > MAX_MS, the latched value is MAX_MS.
- CONVERT: serial shift-add-3 (double dabble), one bit per cycle, exactly 10 cycles, producing 3 BCD digits (hundreds, tens, units). It always runs, regardless of Mode, so latency is uniform.
- FORMAT: one cycle; registers the new Display.
- STROBE: Go=1 for exactly this cycle. Display already holds the new value in this cycle.
- HOLD: count REFRESH_CYCLES cycles, then IDLE; Busy drops on entry to IDLE.
- Latency: Update sampled at cycle 0 -> Go high at cycle 12 -> Busy low at cycle 13+REFRESH_CYCLES.
- Update while Busy=1 is ignored, not queued. Mode and Time changes after acceptance have no effect on the message in progress.
- Display is stable between FORMAT cycles.
- Messages (16 chars, padded with spaces):
  - Mode 0: "PRESS TO START  "
  - Mode 1: "WAIT...         "
  - Mode 2: "TIME: " + D2 D1 D0 + " ms    "; digits at chars 6-8; digit ASCII = 8'h30 + BCD.
  - Mode 3: "TOO SOON!       "

Optional Feature:
- Macro: LCD_ZERO_BLANK_EN.
- Defined: a leading hundreds digit of 0 is shown as a space; the tens digit is shown as a space if it and the hundreds digit are both 0. The units digit is always shown (0 ms -> "  0").
- Undefined: all three digits are always shown ("005", "000").

Decomposition:
- Shared package lcd_fmt_pkg:
  - Mode codes (MODE_READY/WAIT/TIME/EARLY)
  - FSM state encoding
  - ASCII constants (space, '0')
  - Four fixed message strings as 128-bit constants
  - CHARS=16, TIME_W=10
- One sub-module: lcd_bcd_serial, the iterative 10-bit -> 3-digit BCD converter.
  - Inputs: start, value.
  - Outputs: done (pulses on the 10th shift cycle), 12-bit BCD result.

Test Plan:
- Reset asserted for 3 cycles -> Display = 16 spaces (0x20...20), Go=0, Busy=0.
- Mode=2, Time=247, Update pulsed at cycle 0 -> Go=1 only at cycle 12; Display="TIME: 247 ms    "; Busy high cycles 1 through 12+REFRESH_CYCLES.
- Mode=2, Time=1023 -> "TIME: 999 ms    ".
- Time=5 and Time=0:
  - With LCD_ZERO_BLANK_EN: "TIME:   5 ms    " and "TIME:   0 ms    ".
  - Without it: "TIME: 005 ms    " and "TIME: 000 ms    ".
- REFRESH_CYCLES=8:
  - Mode=3 Update, then Mode=0 Update at cycle 5 -> second request ignored, exactly one Go, Display="TOO SOON!       ".
  - Mode=0 Update once Busy=0 -> second Go, Display="PRESS TO START  ".
- Rst pulsed at cycle 6 during CONVERT -> no Go ever issued; Display = spaces; Busy=0; a fresh Update afterwards completes normally with Go at +12.
